// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM port shared between instruction fetch and the
// load/store stage. Load/store has priority; multi-byte transfers are issued
// as consecutive byte cycles, little-endian, with one-cycle done pulses.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no transfer, arbitration of ls_req / if_req
// IF_RD | 4-byte instruction fetch in progress
// LS_RD | 1/2/4-byte load in progress
// LS_WR | 1/2/4-byte store in progress
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_len,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              mem_busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  n_q;
  logic [2:0]  ls_n;
  logic [1:0]  rd_idx;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [31:0] asm_nxt;
  logic        ls_take;
  logic        if_take;
  logic        rd_last;
  logic        wr_last;

  // Byte count of a load/store; the unused encoding 10 behaves as a word.
  always_comb begin
    ls_n = 3'd4;
    if (ls_len == 2'b00)
      ls_n = 3'd1;
    else if (ls_len == 2'b01)
      ls_n = 3'd2;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and arbitration; a requester whose done is high this cycle
  // still has its request up and must not be taken again.
  always_comb begin
    state_nxt = state;
    ls_take   = 1'b0;
    if_take   = 1'b0;
    rd_last   = 1'b0;
    wr_last   = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req && !ls_done) begin
          ls_take   = 1'b1;
          state_nxt = ls_we ? LS_WR : LS_RD;
        end else if (if_req && !if_done && !if_flush) begin
          if_take   = 1'b1;
          state_nxt = IF_RD;
        end
      end
      IF_RD: begin
        if (if_flush) begin
          state_nxt = IDLE;
        end else if (cnt == n_q) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      LS_RD: begin
        if (cnt == n_q) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      LS_WR: begin
        if (cnt == n_q - 3'd1) begin
          wr_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Merge the byte returned for the address issued one cycle earlier.
  always_comb begin
    rd_idx  = cnt[1:0] - 2'd1;
    asm_nxt = asm_q;
    asm_nxt[{rd_idx, 3'b000} +: 8] = ram_din;
  end

  // Datapath: latch the transfer at accept, step address and count, assemble
  // read data, publish results with the done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= 3'd0;
      n_q      <= 3'd0;
      wdata_q  <= 32'h0;
      asm_q    <= 32'h0;
      ram_a    <= '0;
      if_data  <= 32'h0;
      ls_rdata <= 32'h0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if (ls_take) begin
        ram_a   <= ls_addr;
        cnt     <= 3'd0;
        n_q     <= ls_n;
        wdata_q <= ls_wdata;
        asm_q   <= 32'h0;
      end else if (if_take) begin
        ram_a <= if_addr;
        cnt   <= 3'd0;
        n_q   <= 3'd4;
        asm_q <= 32'h0;
      end else if (state == LS_WR || state == LS_RD ||
                   (state == IF_RD && !if_flush)) begin
        cnt <= cnt + 3'd1;
        if (cnt < n_q - 3'd1)
          ram_a <= ram_a + ADDR_W'(1);
        if (state != LS_WR && cnt != 3'd0)
          asm_q <= asm_nxt;
        if (rd_last && state == IF_RD) begin
          if_data <= asm_nxt;
          if_done <= 1'b1;
        end
        if (rd_last && state == LS_RD) begin
          ls_rdata <= asm_nxt;
          ls_done  <= 1'b1;
        end
        if (wr_last)
          ls_done <= 1'b1;
      end
    end
  end

  // RAM write strobe and data; blanked while reset is held so a store that
  // is being abandoned never commits another byte.
  always_comb begin
    mem_busy = (state != IDLE);
    ram_wr   = (state == LS_WR) && rst;
    ram_dout = ram_wr ? wdata_q[{cnt[1:0], 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a RAM model and a cycle
// schedule of expected outputs built from transfer-level rules.
module tb_mem_ctrl;

  localparam int N = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_len;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mem_busy;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'h00;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_busy(mem_busy), .ram_a(ram_a), .ram_dout(ram_dout),
    .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // RAM contents (environment) and expected contents (model)
  logic [7:0] ram_m   [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  // per-cycle expectations, indexed by cycle number
  bit        e_busy  [N];
  bit        e_wr    [N];
  bit [7:0]  e_dout  [N];
  bit        e_a_chk [N];
  bit [31:0] e_a     [N];
  bit        e_ifd   [N];
  bit [31:0] e_ifdata[N];
  bit        e_lsd   [N];
  bit        e_lsv   [N];
  bit [31:0] e_lsdata[N];
  bit        e_rst   [N];

  function automatic logic [7:0] ram_rd(input bit [31:0] a);
    return ram_m.exists(a) ? ram_m[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // byte-wide RAM, read data valid the cycle after the address
  always @(posedge clk) begin
    if ($isunknown(ram_a))
      ram_din <= 8'h00;
    else
      ram_din <= ram_rd(ram_a);
    if (ram_wr === 1'b1)
      ram_m[ram_a] = ram_dout;
  end

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic preload(input bit [31:0] a, input logic [7:0] d);
    ram_m[a]   = d;
    ref_mem[a] = d;
  endtask

  // read of n bytes accepted at the edge ending cycle c0
  task automatic sched_read(input int c0, input bit is_if, input bit [31:0] base, input int n);
    bit [31:0] d;
    d = 32'h0;
    for (int k = 0; k < n; k++) begin
      e_a_chk[c0 + 1 + k] = 1'b1;
      e_a[c0 + 1 + k]     = base + 32'(k);
      d = d | (32'(ref_rd(base + 32'(k))) << (8 * k));
    end
    for (int k = 1; k <= n + 1; k++) e_busy[c0 + k] = 1'b1;
    if (is_if) begin
      e_ifd[c0 + n + 2]    = 1'b1;
      e_ifdata[c0 + n + 2] = d;
    end else begin
      e_lsd[c0 + n + 2]    = 1'b1;
      e_lsv[c0 + n + 2]    = 1'b1;
      e_lsdata[c0 + n + 2] = d;
    end
  endtask

  // store of n bytes accepted at the edge ending cycle c0
  task automatic sched_write(input int c0, input bit [31:0] base, input int n, input bit [31:0] wd);
    for (int k = 0; k < n; k++) begin
      e_a_chk[c0 + 1 + k] = 1'b1;
      e_a[c0 + 1 + k]     = base + 32'(k);
      e_wr[c0 + 1 + k]    = 1'b1;
      e_dout[c0 + 1 + k]  = wd[8 * k +: 8];
      e_busy[c0 + 1 + k]  = 1'b1;
      ref_mem[base + 32'(k)] = wd[8 * k +: 8];
    end
    e_lsd[c0 + n + 1] = 1'b1;
  endtask

  task automatic start_if(input bit [31:0] a, output int c0);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = a;
    c0 = cyc;
    sched_read(c0, 1'b1, a, 4);
  endtask

  task automatic start_ls(input bit we, input logic [1:0] len, input bit [31:0] a,
                          input bit [31:0] wd, output int c0);
    int n;
    @(negedge clk);
    ls_req   = 1'b1;
    ls_we    = we;
    ls_len   = len;
    ls_addr  = a;
    ls_wdata = wd;
    c0 = cyc;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    if (we) sched_write(c0, a, n, wd);
    else    sched_read(c0, 1'b0, a, n);
  endtask

  task automatic wait_done(input bit is_if, input int exp_c, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = is_if ? (if_done === 1'b1) : (ls_done === 1'b1);
    end
    check(seen && cyc == exp_c, name, 32'(cyc), 32'(exp_c));
  endtask

  // per-cycle comparison against the schedule
  initial begin : compare
    logic [31:0] cur_if;
    logic [31:0] cur_ls;
    cur_if = 32'h0;
    cur_ls = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (cyc >= 1 && cyc < N) begin
        if (e_rst[cyc]) begin
          cur_if = 32'h0;
          cur_ls = 32'h0;
        end
        if (e_ifd[cyc]) cur_if = e_ifdata[cyc];
        if (e_lsv[cyc]) cur_ls = e_lsdata[cyc];
        check(mem_busy === e_busy[cyc], "mem_busy", 32'(mem_busy), 32'(e_busy[cyc]));
        check(ram_wr === e_wr[cyc], "ram_wr", 32'(ram_wr), 32'(e_wr[cyc]));
        check(ram_dout === e_dout[cyc], "ram_dout", 32'(ram_dout), 32'(e_dout[cyc]));
        check(if_done === e_ifd[cyc], "if_done", 32'(if_done), 32'(e_ifd[cyc]));
        check(ls_done === e_lsd[cyc], "ls_done", 32'(ls_done), 32'(e_lsd[cyc]));
        check(if_data === cur_if, "if_data", if_data, cur_if);
        check(ls_rdata === cur_ls, "ls_rdata", ls_rdata, cur_ls);
        if (e_a_chk[cyc])
          check(ram_a === e_a[cyc], "ram_a", ram_a, e_a[cyc]);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got no finish, want finish by 20000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0;
    int pulses;
    logic [31:0] wrap_a [4];
    wrap_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_len = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;
    preload(32'h100, 8'h13);
    e_rst[1] = 1'b1; e_a_chk[1] = 1'b1;
    e_rst[2] = 1'b1; e_a_chk[2] = 1'b1;

    // reset held two cycles with a fetch pending, then fetch at 0x100
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    c0 = cyc;
    sched_read(c0, 1'b1, 32'h100, 4);
    wait_done(1'b1, 8, "fetch done cycle");
    check(if_data === 32'h0000_0013, "fetch data", if_data, 32'h0000_0013);
    if_req = 1'b0;

    // simultaneous requests: 2-byte load first, fetch right after
    preload(32'h200, 8'hAB); preload(32'h201, 8'hCD);
    preload(32'h104, 8'h93); preload(32'h105, 8'h00);
    preload(32'h106, 8'h10); preload(32'h107, 8'h00);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 2'b01; ls_addr = 32'h200;
    c0 = cyc;
    sched_read(c0, 1'b0, 32'h200, 2);
    sched_read(c0 + 4, 1'b1, 32'h104, 4);
    wait_done(1'b0, c0 + 4, "arb load done cycle");
    check(ls_rdata === 32'h0000_CDAB, "arb load data", ls_rdata, 32'h0000_CDAB);
    ls_req = 1'b0;
    wait_done(1'b1, c0 + 10, "arb fetch done cycle");
    check(if_data === 32'h0010_0093, "arb fetch data", if_data, 32'h0010_0093);
    if_req = 1'b0;

    // word store then byte store
    start_ls(1'b1, 2'b11, 32'h300, 32'hDEAD_BEEF, c0);
    wait_done(1'b0, c0 + 5, "store word done cycle");
    ls_req = 1'b0;
    check(ram_rd(32'h300) === 8'hEF, "store byte0", 32'(ram_rd(32'h300)), 32'hEF);
    check(ram_rd(32'h301) === 8'hBE, "store byte1", 32'(ram_rd(32'h301)), 32'hBE);
    check(ram_rd(32'h302) === 8'hAD, "store byte2", 32'(ram_rd(32'h302)), 32'hAD);
    check(ram_rd(32'h303) === 8'hDE, "store byte3", 32'(ram_rd(32'h303)), 32'hDE);
    start_ls(1'b1, 2'b00, 32'h310, 32'hDEAD_BEEF, c0);
    wait_done(1'b0, c0 + 2, "store byte done cycle");
    ls_req = 1'b0;
    check(ram_rd(32'h310) === 8'hEF, "store single", 32'(ram_rd(32'h310)), 32'hEF);
    check(ram_rd(32'h311) === 8'h00, "store single extent", 32'(ram_rd(32'h311)), 32'h00);

    // loads: 1 byte zero-extended, and length code 10 as a word
    start_ls(1'b0, 2'b00, 32'h302, 32'h0, c0);
    wait_done(1'b0, c0 + 3, "load byte done cycle");
    ls_req = 1'b0;
    check(ls_rdata === 32'h0000_00AD, "load byte data", ls_rdata, 32'h0000_00AD);
    start_ls(1'b0, 2'b10, 32'h300, 32'h0, c0);
    wait_done(1'b0, c0 + 6, "load len10 done cycle");
    ls_req = 1'b0;
    check(ls_rdata === 32'hDEAD_BEEF, "load len10 data", ls_rdata, 32'hDEAD_BEEF);

    // flush in C2 of a fetch
    preload(32'h120, 8'h55); preload(32'h121, 8'h66);
    start_if(32'h120, c0);
    @(negedge clk);
    @(negedge clk);
    if_flush = 1'b1;
    if_req   = 1'b0;
    for (int c = c0 + 3; c <= c0 + 8; c++) begin
      e_busy[c]  = 1'b0;
      e_ifd[c]   = 1'b0;
      e_a_chk[c] = 1'b0;
    end
    @(negedge clk);
    if_flush = 1'b0;
    check(mem_busy === 1'b0, "flush idle", 32'(mem_busy), 32'h0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_done === 1'b1) pulses++;
    end
    check(pulses == 0, "flush no done", 32'(pulses), 32'h0);
    check(if_data === 32'h0010_0093, "flush data kept", if_data, 32'h0010_0093);

    // flush during a store has no effect
    start_ls(1'b1, 2'b11, 32'h400, 32'h0102_0304, c0);
    if_flush = 1'b1;
    wait_done(1'b0, c0 + 5, "flush store done cycle");
    ls_req   = 1'b0;
    if_flush = 1'b0;
    check(ram_rd(32'h400) === 8'h04, "flush store byte0", 32'(ram_rd(32'h400)), 32'h04);
    check(ram_rd(32'h403) === 8'h01, "flush store byte3", 32'(ram_rd(32'h403)), 32'h01);

    // fetch across the top of the address space
    preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
    preload(32'h0000_0000, 8'h33); preload(32'h0000_0001, 8'h44);
    start_if(32'hFFFF_FFFE, c0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check(ram_a === wrap_a[k], "wrap ram_a", ram_a, wrap_a[k]);
    end
    wait_done(1'b1, c0 + 6, "wrap fetch done cycle");
    if_req = 1'b0;
    check(if_data === 32'h4433_2211, "wrap fetch data", if_data, 32'h4433_2211);

    // reset while the second byte of a store is on the port
    start_ls(1'b1, 2'b11, 32'h500, 32'hA1B2_C3D4, c0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    ls_req = 1'b0;
    e_wr[c0 + 2]   = 1'b0;
    e_dout[c0 + 2] = 8'h00;
    for (int c = c0 + 3; c <= c0 + 6; c++) begin
      e_busy[c]  = 1'b0;
      e_wr[c]    = 1'b0;
      e_dout[c]  = 8'h00;
      e_lsd[c]   = 1'b0;
      e_a_chk[c] = 1'b0;
    end
    e_rst[c0 + 3]   = 1'b1;
    e_a_chk[c0 + 3] = 1'b1;
    e_a[c0 + 3]     = 32'h0;
    for (int k = 1; k < 4; k++) ref_mem.delete(32'h500 + 32'(k));
    @(negedge clk);
    rst = 1'b1;
    check(ram_wr === 1'b0, "reset store ram_wr", 32'(ram_wr), 32'h0);
    check(mem_busy === 1'b0, "reset store busy", 32'(mem_busy), 32'h0);
    check(ram_rd(32'h500) === 8'hD4, "reset store byte0", 32'(ram_rd(32'h500)), 32'hD4);
    check(ram_rd(32'h501) === 8'h00, "reset store byte1", 32'(ram_rd(32'h501)), 32'h00);
    @(negedge clk);
    check(if_data === 32'h0, "reset if_data", if_data, 32'h0);
    check(ls_rdata === 32'h0, "reset ls_rdata", ls_rdata, 32'h0);

    @(negedge clk);
    @(negedge clk);
    foreach (ref_mem[a])
      check(ram_rd(a) === ref_mem[a], "ram contents", 32'(ram_rd(a)), 32'(ref_mem[a]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
